// File: rtl/disp_sched.sv
// disp_sched: schedules the shared 4-digit 7-segment display between four base
// screens and three prioritised overlay requesters.
//
// Base screen src[base_sel] is shown while idle. An overlay request borrows the
// display for HOLD_CYCLES cycles. When blink is enabled, the overlay alternates
// visible/blank every BLINK_CYCLES cycles. Each overlay is followed by one BLANK
// gap cycle. Requester 0 has the highest priority.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   base_sel            base screen select (src0..src3)
//   src0..3_data        base screen glyph words
//   ovl_req[2:0]        one-cycle overlay request pulses
//   ovl0..2_data        overlay glyph words, captured at grant
//   ovl_blink[2:0]      per-requester blink enable, captured at grant
//   ovl_cancel          drops the active overlay and all pending requests
//   ovl_ack[2:0]        one-cycle grant pulse
//   busy                overlay shown or pending
//   active_id           requester being shown, 3 = none
//   disp                registered glyph word to the display driver
module disp_sched #(
    parameter int          HOLD_CYCLES  = 50000000,
    parameter int          BLINK_CYCLES = 12500000,
    parameter logic [19:0] BLANK        = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  base_sel,
    input  logic [19:0] src0_data,
    input  logic [19:0] src1_data,
    input  logic [19:0] src2_data,
    input  logic [19:0] src3_data,
    input  logic [2:0]  ovl_req,
    input  logic [19:0] ovl0_data,
    input  logic [19:0] ovl1_data,
    input  logic [19:0] ovl2_data,
    input  logic [2:0]  ovl_blink,
    input  logic        ovl_cancel,
    output logic [2:0]  ovl_ack,
    output logic        busy,
    output logic [1:0]  active_id,
    output logic [19:0] disp
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [1:0] ID_NONE = 2'd3;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    pending_q, pending_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bphase_q, bphase_d;   // 1 = blank half of the blink period
    logic          blink_en_q, blink_en_d;
    logic [19:0]   data_q, data_d;
    logic [19:0]   disp_q, disp_d;
    logic [2:0]    ack_q, ack_d;
    logic          busy_q, busy_d;
    logic [1:0]    active_q, active_d;

    logic [2:0]    eff;
    logic [1:0]    win;
    logic [2:0]    win_mask;
    logic [19:0]   base_word;
    logic [19:0]   win_data;
    logic          grant;

    always_comb begin
        eff = pending_q | ovl_req;
        if (eff[0]) begin
            win = 2'd0; win_mask = 3'b001; win_data = ovl0_data;
        end else if (eff[1]) begin
            win = 2'd1; win_mask = 3'b010; win_data = ovl1_data;
        end else begin
            win = 2'd2; win_mask = 3'b100; win_data = ovl2_data;
        end
        case (base_sel)
            2'd0:    base_word = src0_data;
            2'd1:    base_word = src1_data;
            2'd2:    base_word = src2_data;
            default: base_word = src3_data;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        hold_d     = hold_q;
        bcnt_d     = bcnt_q;
        bphase_d   = bphase_q;
        blink_en_d = blink_en_q;
        data_d     = data_q;
        disp_d     = disp_q;
        ack_d      = 3'b000;
        active_d   = active_q;
        grant      = 1'b0;

        if (ovl_cancel) begin
            // Cancel wins over same-cycle requests; they are dropped unacked.
            state_d   = IDLE;
            pending_d = 3'b000;
            active_d  = ID_NONE;
            disp_d    = base_word;
        end else begin
            case (state_q)
                IDLE: begin
                    disp_d = base_word;
                    if (eff != 3'b000) grant = 1'b1;
                end
                SHOW: begin
                    pending_d = eff;
                    // Pending bits are always above active_q, so a winner at or
                    // below active_q can only come from a fresh request.
                    if (eff != 3'b000 && win <= active_q) begin
                        grant = 1'b1;
                    end else if (hold_q == '0) begin
                        state_d  = GAP;
                        active_d = ID_NONE;
                        disp_d   = BLANK;
                    end else begin
                        hold_d = hold_q - HW'(1);
                        if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
                            bcnt_d   = '0;
                            bphase_d = ~bphase_q;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                        disp_d = (blink_en_q && bphase_d) ? BLANK : data_q;
                    end
                end
                GAP: begin
                    pending_d = eff;
                    if (eff != 3'b000) begin
                        grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        disp_d  = base_word;
                    end
                end
                default: begin
                    state_d = IDLE;
                    disp_d  = BLANK;
                end
            endcase

            if (grant) begin
                // A preempted overlay is simply overwritten, never re-queued.
                state_d    = SHOW;
                pending_d  = eff & ~win_mask;
                data_d     = win_data;
                blink_en_d = ovl_blink[win];
                active_d   = win;
                ack_d      = win_mask;
                hold_d     = HW'(HOLD_CYCLES - 1);
                bcnt_d     = '0;
                bphase_d   = 1'b0;
                disp_d     = win_data;
            end
        end

        busy_d = (state_d != IDLE) || (pending_d != 3'b000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 3'b000;
            hold_q     <= '0;
            bcnt_q     <= '0;
            bphase_q   <= 1'b0;
            blink_en_q <= 1'b0;
            data_q     <= BLANK;
            disp_q     <= BLANK;
            ack_q      <= 3'b000;
            busy_q     <= 1'b0;
            active_q   <= ID_NONE;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            hold_q     <= hold_d;
            bcnt_q     <= bcnt_d;
            bphase_q   <= bphase_d;
            blink_en_q <= blink_en_d;
            data_q     <= data_d;
            disp_q     <= disp_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            active_q   <= active_d;
        end
    end

    assign ovl_ack   = ack_q;
    assign busy      = busy_q;
    assign active_id = active_q;
    assign disp      = disp_q;

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched (HOLD_CYCLES=8, BLINK_CYCLES=2).
// Stimulus sets inputs just after a falling edge, then pushes the output word
// expected after the next rising edge. The monitor pops one entry per rising
// edge and compares each output field.
module tb_disp_sched;

    localparam logic [19:0] BLANK = 20'hFFFFF;
    localparam logic [19:0] S0    = 20'h0A0B1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  base_sel;
    logic [19:0] src0_data, src1_data, src2_data, src3_data;
    logic [2:0]  ovl_req;
    logic [19:0] ovl0_data, ovl1_data, ovl2_data;
    logic [2:0]  ovl_blink;
    logic        ovl_cancel;
    logic [2:0]  ovl_ack;
    logic        busy;
    logic [1:0]  active_id;
    logic [19:0] disp;

    disp_sched #(.HOLD_CYCLES(8), .BLINK_CYCLES(2), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .base_sel(base_sel),
        .src0_data(src0_data), .src1_data(src1_data),
        .src2_data(src2_data), .src3_data(src3_data),
        .ovl_req(ovl_req), .ovl0_data(ovl0_data), .ovl1_data(ovl1_data),
        .ovl2_data(ovl2_data), .ovl_blink(ovl_blink), .ovl_cancel(ovl_cancel),
        .ovl_ack(ovl_ack), .busy(busy), .active_id(active_id), .disp(disp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] disp;
        logic [2:0]  ack;
        logic        busy;
        logic [1:0]  aid;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic tick(input string name, input logic [19:0] d,
                        input logic [2:0] a, input logic b, input logic [1:0] id);
        exp_t e;
        e.name = name; e.disp = d; e.ack = a; e.busy = b; e.aid = id;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input string name, input int n, input logic [19:0] d,
                       input logic b, input logic [1:0] id);
        for (int i = 0; i < n; i++) tick(name, d, 3'b000, b, id);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk += 4;
            if (disp === e.disp) n_pass++;
            else $display("FAIL %s disp: got %h want %h", e.name, disp, e.disp);
            if (ovl_ack === e.ack) n_pass++;
            else $display("FAIL %s ack: got %b want %b", e.name, ovl_ack, e.ack);
            if (busy === e.busy) n_pass++;
            else $display("FAIL %s busy: got %b want %b", e.name, busy, e.busy);
            if (active_id === e.aid) n_pass++;
            else $display("FAIL %s active_id: got %0d want %0d", e.name, active_id, e.aid);
        end
    end

    initial begin
        rst = 1'b1; base_sel = 2'd2;
        src0_data = 20'h00000; src1_data = 20'h11111;
        src2_data = 20'h12345; src3_data = 20'h33333;
        ovl_req = 3'b000; ovl_blink = 3'b000; ovl_cancel = 1'b0;
        ovl0_data = 20'h0; ovl1_data = 20'h0; ovl2_data = 20'h0;
        tick("reset", BLANK, 3'b000, 1'b0, 2'd3);
        tick("reset2", BLANK, 3'b000, 1'b0, 2'd3);

        // Idle base screen follows base_sel with one cycle latency
        rst = 1'b0;
        tick("idle_src2", 20'h12345, 3'b000, 1'b0, 2'd3);
        base_sel = 2'd0; src0_data = S0;
        tick("idle_src0", S0, 3'b000, 1'b0, 2'd3);

        // Single overlay, no blink: 8 visible cycles, 1 gap, base
        ovl1_data = 20'h0540B; ovl_req = 3'b010;
        tick("single_ack", 20'h0540B, 3'b010, 1'b1, 2'd1);
        ovl_req = 3'b000;
        run("single_hold", 7, 20'h0540B, 1'b1, 2'd1);
        tick("single_gap", BLANK, 3'b000, 1'b1, 2'd3);
        tick("single_idle", S0, 3'b000, 1'b0, 2'd3);

        // Blink: d,d,B,B,d,d,B,B then gap
        ovl2_data = 20'h22222; ovl_blink = 3'b100; ovl_req = 3'b100;
        tick("blink_ack", 20'h22222, 3'b100, 1'b1, 2'd2);
        ovl_req = 3'b000; ovl_blink = 3'b000;
        tick("blink1", 20'h22222, 3'b000, 1'b1, 2'd2);
        tick("blink2", BLANK,     3'b000, 1'b1, 2'd2);
        tick("blink3", BLANK,     3'b000, 1'b1, 2'd2);
        tick("blink4", 20'h22222, 3'b000, 1'b1, 2'd2);
        tick("blink5", 20'h22222, 3'b000, 1'b1, 2'd2);
        tick("blink6", BLANK,     3'b000, 1'b1, 2'd2);
        tick("blink7", BLANK,     3'b000, 1'b1, 2'd2);
        tick("blink_gap", BLANK,  3'b000, 1'b1, 2'd3);
        tick("blink_idle", S0,    3'b000, 1'b0, 2'd3);

        // Priority, queueing and preemption
        ovl1_data = 20'h11AAA; ovl2_data = 20'h22BBB; ovl_req = 3'b110;
        tick("prio_ack1", 20'h11AAA, 3'b010, 1'b1, 2'd1);
        ovl_req = 3'b000;
        run("prio_hold1", 7, 20'h11AAA, 1'b1, 2'd1);
        tick("prio_gap", BLANK, 3'b000, 1'b1, 2'd3);
        tick("prio_ack2", 20'h22BBB, 3'b100, 1'b1, 2'd2);
        run("prio_hold2", 2, 20'h22BBB, 1'b1, 2'd2);
        ovl0_data = 20'h0C0C0; ovl_req = 3'b001;
        tick("preempt_ack0", 20'h0C0C0, 3'b001, 1'b1, 2'd0);
        ovl_req = 3'b000;
        run("preempt_hold", 7, 20'h0C0C0, 1'b1, 2'd0);
        tick("preempt_gap", BLANK, 3'b000, 1'b1, 2'd3);
        tick("preempt_idle", S0, 3'b000, 1'b0, 2'd3);

        // Retrigger at hold count 3; base_sel change during SHOW is ignored
        ovl1_data = 20'h05555; ovl_req = 3'b010;
        tick("retrig_ack1", 20'h05555, 3'b010, 1'b1, 2'd1);
        ovl_req = 3'b000;
        run("retrig_first", 4, 20'h05555, 1'b1, 2'd1);
        ovl1_data = 20'h00001; ovl_req = 3'b010;
        tick("retrig_ack2", 20'h00001, 3'b010, 1'b1, 2'd1);
        ovl_req = 3'b000; base_sel = 2'd3;
        run("retrig_hold", 7, 20'h00001, 1'b1, 2'd1);
        tick("retrig_gap", BLANK, 3'b000, 1'b1, 2'd3);
        tick("retrig_idle_src3", 20'h33333, 3'b000, 1'b0, 2'd3);
        base_sel = 2'd0;
        tick("idle_back_src0", S0, 3'b000, 1'b0, 2'd3);

        // Cancel with ovl2 pending and a same-cycle ovl1 request
        ovl0_data = 20'h0D0D0; ovl_req = 3'b001;
        tick("cancel_ack0", 20'h0D0D0, 3'b001, 1'b1, 2'd0);
        ovl_req = 3'b100;
        tick("cancel_pend", 20'h0D0D0, 3'b000, 1'b1, 2'd0);
        ovl_req = 3'b010; ovl_cancel = 1'b1;
        tick("cancel", S0, 3'b000, 1'b0, 2'd3);
        ovl_req = 3'b000; ovl_cancel = 1'b0;
        run("cancel_after", 2, S0, 1'b0, 2'd3);

        // Reset mid-SHOW
        ovl1_data = 20'h0540B; ovl_req = 3'b010;
        tick("rst_ack", 20'h0540B, 3'b010, 1'b1, 2'd1);
        ovl_req = 3'b000;
        tick("rst_show", 20'h0540B, 3'b000, 1'b1, 2'd1);
        rst = 1'b1;
        tick("rst_mid", BLANK, 3'b000, 1'b0, 2'd3);
        rst = 1'b0;
        tick("rst_idle", S0, 3'b000, 1'b0, 2'd3);
        run("rst_stay", 2, S0, 1'b0, 2'd3);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
